audio_mix_sched: RTL and testbench

AUDIO_MIX_SCHED -- requirements
Module: audio_mix_sched

---
 rtl/audio_mix_sched.sv | 153 +++++++++++++++
 tb/tb_audio_mix_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/audio_mix_sched.sv
// Four-channel audio mixer feeding a sigma-delta DAC input.
// Each channel has a one-deep buffer. Once per sample period the FSM adds
// every enabled channel, attenuated by its shift, and registers the result.
// Build option: define AUDIO_MIX_SAT_EN to saturate the mix to audio_bits;
// otherwise the low audio_bits of the accumulator pass through and wrap.
module audio_mix_sched #(
  parameter int audio_bits = 16,
  parameter int sample_div = 1024
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [4*audio_bits-1:0] ch_data,
  input  logic [3:0]              ch_valid,
  output logic [3:0]              ch_ready,
  input  logic [3:0]              ch_enable,
  input  logic [7:0]              ch_atten,
  input  logic                    mute,
  input  logic                    underrun_clr,
  output logic [audio_bits-1:0]   out_d,
  output logic                    out_strobe,
  output logic [3:0]              underrun
);

  localparam int unsigned acc_w = audio_bits + 2;
  localparam int unsigned cnt_w = 16;

  typedef enum logic [2:0] {IDLE, ACC0, ACC1, ACC2, ACC3, OUT} state_t;

  state_t                  state;
  logic [cnt_w-1:0]        cnt;
  logic                    tick;
  logic [3:0]              full;
  logic [audio_bits-1:0]   sreg [4];
  logic [audio_bits-1:0]   last [4];
  logic signed [acc_w-1:0] acc;
  logic                    acc_act;
  logic [1:0]              acc_ch;
  logic signed [audio_bits-1:0] sel_s;
  logic signed [audio_bits-1:0] shifted;
  logic [1:0]              sel_atten;
  logic signed [acc_w-1:0] contrib;
  logic [audio_bits-1:0]   lim;

  assign tick     = (cnt == cnt_w'(sample_div - 1));
  assign ch_ready = ~full | ~ch_enable;

  // Sample-rate divider, wraps at sample_div-1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + cnt_w'(1);
  end

  // Decode which channel the current accumulate state serves.
  always_comb begin
    acc_act = 1'b0;
    acc_ch  = 2'd0;
    case (state)
      ACC0: begin acc_act = 1'b1; acc_ch = 2'd0; end
      ACC1: begin acc_act = 1'b1; acc_ch = 2'd1; end
      ACC2: begin acc_act = 1'b1; acc_ch = 2'd2; end
      ACC3: begin acc_act = 1'b1; acc_ch = 2'd3; end
      default: ;
    endcase
  end

  // Contribution: fresh sample if buffered, else repeat last; zero if disabled.
  always_comb begin
    sel_s     = full[acc_ch] ? sreg[acc_ch] : last[acc_ch];
    sel_atten = ch_atten[{acc_ch, 1'b0} +: 2];
    shifted   = sel_s >>> sel_atten;
    contrib   = '0;
    if (acc_act && ch_enable[acc_ch])
      contrib = {{2{shifted[audio_bits-1]}}, shifted};
  end

`ifdef AUDIO_MIX_SAT_EN
  localparam logic signed [acc_w-1:0] sat_max = acc_w'((1 << (audio_bits - 1)) - 1);
  localparam logic signed [acc_w-1:0] sat_min = -sat_max - acc_w'(1);

  // Clamp the accumulator into the output sample range.
  always_comb begin
    if (acc > sat_max)      lim = sat_max[audio_bits-1:0];
    else if (acc < sat_min) lim = sat_min[audio_bits-1:0];
    else                    lim = acc[audio_bits-1:0];
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[acc_w-1:audio_bits];

  // Wrap-around: keep only the low sample bits.
  always_comb begin
    lim = acc[audio_bits-1:0];
  end
`endif

  // Channel buffers, last-sample memory and sticky underrun flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      full     <= '0;
      underrun <= '0;
      for (int n = 0; n < 4; n++) begin
        sreg[n] <= '0;
        last[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (!ch_enable[n]) begin
          full[n] <= 1'b0;
        end else if (acc_act && (acc_ch == 2'(n)) && full[n]) begin
          full[n] <= 1'b0;
          last[n] <= sreg[n];
        end else if (ch_valid[n] && ch_ready[n]) begin
          sreg[n] <= ch_data[n*audio_bits +: audio_bits];
          full[n] <= 1'b1;
        end
        if (acc_act && (acc_ch == 2'(n)) && ch_enable[n] && !full[n])
          underrun[n] <= 1'b1;
        else if (underrun_clr)
          underrun[n] <= 1'b0;
      end
    end
  end

  // Mix sequencer: accumulate four channels, then register the output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      acc        <= '0;
      out_d      <= '0;
      out_strobe <= 1'b0;
    end else begin
      out_strobe <= 1'b0;
      case (state)
        IDLE: if (tick) begin
          state <= ACC0;
          acc   <= '0;
        end
        ACC0: begin acc <= acc + contrib; state <= ACC1; end
        ACC1: begin acc <= acc + contrib; state <= ACC2; end
        ACC2: begin acc <= acc + contrib; state <= ACC3; end
        ACC3: begin acc <= acc + contrib; state <= OUT;  end
        OUT: begin
          out_d      <= mute ? '0 : lim;
          out_strobe <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mix_sched.sv
// Directed bench for audio_mix_sched with a short sample period.
module tb_audio_mix_sched;

  localparam int aw = 16;
  localparam int sd = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [4*aw-1:0] ch_data;
  logic [3:0]    ch_valid;
  logic [3:0]    ch_ready;
  logic [3:0]    ch_enable;
  logic [7:0]    ch_atten;
  logic          mute;
  logic          underrun_clr;
  logic [aw-1:0] out_d;
  logic          out_strobe;
  logic [3:0]    underrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  audio_mix_sched #(.audio_bits(aw), .sample_div(sd)) dut (
    .clk(clk), .reset_n(reset_n), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .ch_enable(ch_enable), .ch_atten(ch_atten),
    .mute(mute), .underrun_clr(underrun_clr), .out_d(out_d),
    .out_strobe(out_strobe), .underrun(underrun)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // One-cycle offer on the channels in mask m.
  task automatic offer(input logic [3:0] m, input logic [4*aw-1:0] d);
    @(negedge clk);
    ch_data  = d;
    ch_valid = m;
    @(posedge clk);
    #1;
    ch_valid = '0;
  endtask

  // Count rising edges until out_strobe is seen, bounded.
  task automatic wait_strobe(input int start, output int n);
    n = start;
    do begin
      @(posedge clk);
      #1;
      ch_valid = '0;
      n++;
    end while (!out_strobe && n < 4*sd);
    check("strobe_seen", 32'(out_strobe), 32'd1);
  endtask

  task automatic mix_check(input string tag, input logic [aw-1:0] exp);
    int n;
    wait_strobe(0, n);
    check(tag, 32'(out_d), 32'(exp));
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(out_strobe), 32'd0);
    check({tag, "_hold"}, 32'(out_d), 32'(exp));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int n;
    int e;
    logic [aw-1:0] exp_sat;
    reset_n      = 1'b0;
    ch_data      = '0;
    ch_valid     = '0;
    ch_enable    = 4'b0001;
    ch_atten     = '0;
    mute         = 1'b0;
    underrun_clr = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_d", 32'(out_d), 32'd0);
    check("rst_strobe", 32'(out_strobe), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_ready", 32'(ch_ready), 32'hF);

    // Single channel, first mix after release.
    @(negedge clk);
    reset_n  = 1'b1;
    ch_data  = 64'h1000;
    ch_valid = 4'b0001;
    @(posedge clk);
    #1;
    ch_valid = '0;
    check("ch0_full_ready", 32'(ch_ready[0]), 32'd0);
    wait_strobe(1, n);
    check("first_latency", 32'(n), 32'(sd + 5));
    check("single_out", 32'(out_d), 32'h1000);
    check("ch0_ready_after", 32'(ch_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    check("single_pulse", 32'(out_strobe), 32'd0);

    // Four full-scale-ish channels overflow the sample range.
`ifdef AUDIO_MIX_SAT_EN
    exp_sat = 16'h7FFF;
`else
    exp_sat = 16'h8000;
`endif
    @(negedge clk);
    ch_enable = 4'b1111;
    offer(4'b1111, {4{16'h6000}});
    mix_check("sum4", exp_sat);
    check("sum4_underrun", 32'(underrun), 32'd0);

    // Underrun: one sample then silence repeats the last value.
    @(negedge clk);
    ch_enable = 4'b0010;
    offer(4'b0010, {16'h0, 16'h0, 16'h0800, 16'h0});
    mix_check("ur_mix1", 16'h0800);
    check("ur_flag1", 32'(underrun), 32'd0);
    mix_check("ur_mix2", 16'h0800);
    check("ur_flag2", 32'(underrun), 32'h2);
    mix_check("ur_mix3", 16'h0800);
    check("ur_flag3", 32'(underrun), 32'h2);
    @(negedge clk);
    underrun_clr = 1'b1;
    @(negedge clk);
    underrun_clr = 1'b0;
    check("ur_clear", 32'(underrun), 32'd0);

    // Attenuation: ch2 >>> 2, ch3 >>> 1.
    e = (16384 >>> 2) + ((-16384) >>> 1);
    @(negedge clk);
    ch_enable = 4'b1100;
    ch_atten  = 8'b01_10_00_00;
    offer(4'b1100, {16'hC000, 16'h4000, 16'h0, 16'h0});
    mix_check("atten", aw'(e));
    check("atten_underrun", 32'(underrun), 32'd0);

    // Mute still consumes the buffer and updates last.
    @(negedge clk);
    ch_atten  = '0;
    ch_enable = 4'b0001;
    mute      = 1'b1;
    offer(4'b0001, 64'h1234);
    mix_check("mute", 16'h0000);
    check("mute_consumed", 32'(ch_ready[0]), 32'd1);
    check("mute_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    mute = 1'b0;
    mix_check("unmute", 16'h1234);
    check("unmute_underrun", 32'(underrun), 32'h1);

    // Disabling a full channel drops its buffered sample.
    offer(4'b0001, 64'h0555);
    check("drop_full", 32'(ch_ready[0]), 32'd0);
    @(negedge clk);
    ch_enable = 4'b0000;
    @(negedge clk);
    ch_enable = 4'b0001;
    #1;
    check("drop_ready", 32'(ch_ready[0]), 32'd1);
    mix_check("drop_mix", 16'h1234);

    // Reset in the middle of ACC2 abandons the mix.
    repeat (sd - 4) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_out_d", 32'(out_d), 32'd0);
    check("midrst_strobe", 32'(out_strobe), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    wait_strobe(0, n);
    check("midrst_latency", 32'(n), 32'(sd + 5));
    check("midrst_out", 32'(out_d), 32'd0);
    check("midrst_ur", 32'(underrun), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
